// File: rtl/pipelined_skip_adder_pkg.sv
// Shared definitions for the pipelined carry-skip adder.
//   DEF_N / DEF_BLOCK / DEF_STAGES : default width, skip-group size and
//                                   pipeline depth.
//   signed_overflow()              : two's-complement overflow from the
//                                   operand and result sign bits. It is
//                                   reused by the other library adders.
package pipelined_skip_adder_pkg;

  localparam int DEF_N      = 32;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 2;

  // Overflow happens when both operands have the same sign and the result
  // sign differs from it. b_msb must be the effective (possibly inverted)
  // operand sign.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_skip_adder_skip_group.sv
// One carry-skip group: a BLOCK-bit ripple adder plus a group propagate
// AND and the skip mux.
//   a, b : group operand slices
//   cin  : carry into the group
//   sum  : group sum bits
//   cout : carry out of the group
module pipelined_skip_adder_skip_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] rc;
  logic           p;

  always_comb begin
    rc    = '0;
    sum   = '0;
    rc[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ rc[i];
      rc[i+1] = (a[i] & b[i]) | (rc[i] & (a[i] ^ b[i]));
    end
  end

  // When every bit propagates, the group carry out equals cin. The mux lets
  // the carry bypass the ripple chain, so the skip path is the carry path.
  assign p    = &(a ^ b);
  assign cout = p ? cin : rc[BLOCK];

endmodule

// File: rtl/pipelined_skip_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready streaming ports.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake
//   A, B, Cin, Sub      : operands; Sub=1 gives A-B and ignores Cin
//   out_valid/out_ready : result handshake
//   Sum, Cout, Overflow : result, MSB carry (1 = no borrow), signed overflow
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holding valid keeps its data stable until the transfer.
// out_valid and the result hold while out_ready is low. in_ready may depend
// combinationally on out_ready.
//
// The N/BLOCK groups are split evenly over STAGES register stages. Stage k
// computes its G groups from the carry registered by stage k-1 and passes
// the partial Sum, the operands and its carry to the next stage.
module pipelined_skip_adder
  import pipelined_skip_adder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Overflow
);

  localparam int GROUPS = N / BLOCK;
  localparam int G      = GROUPS / STAGES;  // groups per stage
  localparam int SW     = G * BLOCK;        // bits completed per stage
  localparam int LAST   = STAGES - 1;

  if ((N % BLOCK) != 0) begin : g_bad_block
    $error("pipelined_skip_adder: N must be a multiple of BLOCK");
  end
  if ((GROUPS % STAGES) != 0) begin : g_bad_stages
    $error("pipelined_skip_adder: N/BLOCK must be a multiple of STAGES");
  end

  // Stage registers
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      bx_q  [STAGES];
  logic [N-1:0]      sum_q [STAGES];
  logic              rdy_q;  // low until the first edge after reset release

  // Stage inputs: stage 0 takes the conditioned port operands, and stage k
  // takes register k-1.
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [N-1:0]      a_src   [STAGES];
  logic [N-1:0]      bx_src  [STAGES];
  logic [N-1:0]      sum_src [STAGES];

  // Stage outputs, captured by the stage register when it advances
  logic [STAGES-1:0] c_nx;
  logic [N-1:0]      sum_nx [STAGES];

  logic [STAGES-1:0] adv;

  // Subtract is A + ~B + 1.
  assign a_src[0]   = A;
  assign bx_src[0]  = Sub ? ~B : B;
  assign c_src[0]   = Sub | Cin;
  assign sum_src[0] = '0;
  assign v_src[0]   = in_valid & in_ready;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign a_src[k]   = a_q[k-1];
    assign bx_src[k]  = bx_q[k-1];
    assign c_src[k]   = c_q[k-1];
    assign sum_src[k] = sum_q[k-1];
    assign v_src[k]   = v_q[k-1];
  end

  // Stage k can take new data unless it and every stage after it are full
  // while the output is stalled. This is the advance chain without a
  // combinational loop through adv.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&v_q[LAST:k]);
  end

  assign in_ready = rdy_q & adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [G:0]    cc;
    logic [SW-1:0] part;
    logic [N-1:0]  merged;

    assign cc[0] = c_src[k];

    for (genvar g = 0; g < G; g++) begin : g_grp
      pipelined_skip_adder_skip_group #(.BLOCK(BLOCK)) u_grp (
        .a    (a_src[k][(k*G+g)*BLOCK +: BLOCK]),
        .b    (bx_src[k][(k*G+g)*BLOCK +: BLOCK]),
        .cin  (cc[g]),
        .sum  (part[g*BLOCK +: BLOCK]),
        .cout (cc[g+1])
      );
    end

    always_comb begin
      merged            = sum_src[k];
      merged[k*SW +: SW] = part;
    end

    assign sum_nx[k] = merged;
    assign c_nx[k]   = cc[G];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      v_q   <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k]   <= v_src[k];
          c_q[k]   <= c_nx[k];
          a_q[k]   <= a_src[k];
          bx_q[k]  <= bx_src[k];
          sum_q[k] <= sum_nx[k];
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign Sum       = sum_q[LAST];
  assign Cout      = c_q[LAST];
  assign Overflow  = signed_overflow(a_q[LAST][N-1], bx_q[LAST][N-1],
                                     sum_q[LAST][N-1]);

endmodule
